player_executor: RTL and testbench
==================================

PLAYER_EXECUTOR -- requirements
Module: player_executor

Interface
REQ-001 SHALL take parameters: BOX_LEFT 220, BOX_RIGHT 420, BOX_TOP 260, BOX_BOTTOM 420 (10-bit pixel bounds, inclusive); STEP 2 (pixels per move); MOVE_DIV 250000 (cycles between moves); IFRAME 25000000 (cycles of invulnerability after a hit); HP_MAX 100.
REQ-002 SHALL use one clock, clk; reset is asynchronous and active-high, named rst.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  async active-high reset.
REQ-005 playerInstruction  input  16  instruction word: [15:12] opcode, [11:8] direction, [7:0] operand.
REQ-006 instrValid  input  1  playerInstruction is valid this cycle.
REQ-007 instrReady  output  1  executor accepts an instruction this cycle.
REQ-008 playerX, playerY  output  10 each  player sprite top-left pixel.
REQ-009 playerHP  output  8  current player HP.
REQ-010 isDeath  output  1  level, high while in DEAD.
REQ-011 isDodging  output  1  level, high while in DODGE.
REQ-012 isInvuln  output  1  high while the invulnerability counter is nonzero.

Function
REQ-013 SHALL accept an instruction on a cycle where instrValid and instrReady are both high; instrReady SHALL be high in every state except during reset.
REQ-014 SHALL implement states IDLE, DODGE, DEAD.
- IDLE -> DODGE on IDG.
- DODGE -> IDLE on SDG.
- DODGE -> DEAD when HP reaches 0.
- DEAD -> IDLE on SHP with operand > 0.
REQ-015 Opcodes: HPY=1 heal, DPY=2 damage, IDG=3 init dodge, SDG=4 stop dodge, MOV=5 move, SHP=6 set HP; opcode 0 and 7-15 are NOPs.
REQ-016 HPY SHALL add the operand to HP, saturating at HP_MAX; ignored in DEAD.
REQ-017 DPY in DODGE, with isInvuln low, SHALL:
- subtract the operand from HP, saturating at 0;
- load the invulnerability counter with IFRAME.
DPY SHALL be ignored in IDLE, in DEAD, or while isInvuln is high.
REQ-018 IDG SHALL set playerX to (BOX_LEFT+BOX_RIGHT)/2 and playerY to (BOX_TOP+BOX_BOTTOM)/2, clear the move counter, and clear the invulnerability counter; ignored in DEAD.
REQ-019 MOV SHALL take effect only in DODGE when the move counter is 0; otherwise it is dropped, not queued.
REQ-020 Executed MOV directions: 0 up (Y-STEP), 1 right (X+STEP), 2 down (Y+STEP), 3 left (X-STEP); directions 4-15 are NOPs.
REQ-021 MOV results SHALL clamp to the box bounds; no wrap-around, including when a coordinate is already within STEP of a bound.
REQ-022 An executed MOV SHALL load the move counter with MOVE_DIV-1; the counter decrements by 1 per cycle down to 0.
REQ-023 SHP SHALL set HP to min(operand, HP_MAX) in any state; SHP 0 while in DODGE SHALL enter DEAD.
REQ-024 The invulnerability counter SHALL decrement by 1 per cycle while nonzero, in any state.
REQ-025 All outputs SHALL be registered; effects of an accepted instruction SHALL be visible on the next clk edge (latency 1).
REQ-026 DPY that brings HP to 0 SHALL raise isDeath on the same edge the HP update appears.
REQ-027 With instrValid low, only the counters change.

Reset
REQ-028 On rst high, immediately and independent of clk:
- state IDLE;
- playerHP = HP_MAX;
- playerX and playerY at box centre;
- both counters 0;
- isDeath, isDodging, isInvuln, instrReady all 0.
REQ-029 Reset asserted mid-move or mid-invulnerability SHALL discard all progress; instrReady SHALL rise on the first clk edge after rst falls.

Structure
REQ-030 Opcode, direction and state encodings SHALL live in a shared package, common with the game state machine that issues these instructions.
REQ-031 The saturating clamp/add arithmetic SHALL be one sub-module, sat_clamp, instantiated for X, Y and HP; the rest of the block is flat.

Verification (MOVE_DIV=4, IFRAME=8)
REQ-032 Reset, then IDG -> playerX=320, playerY=340, isDodging=1, HP=100.
REQ-033 In DODGE, MOV right on 3 consecutive cycles -> X=322 after the first; the next 2 are dropped; a MOV right 4 cycles after the first -> X=324.
REQ-034 Y=262, then MOV up twice with spacing allowed -> Y=260 then Y=260 (clamped), never 1023.
REQ-035 DPY 30, then DPY 30 two cycles later -> HP=70 with the second ignored; DPY 30 nine cycles after the first -> HP=40.
REQ-036 HP=20, DPY 50 -> HP=0 and isDeath=1 on the same edge; MOV ignored; SHP 100 -> IDLE, HP=100, isDeath=0.
REQ-037 rst asserted while the invulnerability counter is 5 -> isInvuln=0, HP=100 immediately without a clk edge.

Source files
------------

// File: rtl/player_executor_pkg.sv
// Shared encodings for the player executor and the game FSM that feeds it.
// Opcodes, move directions and executor states.
package player_executor_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_HPY = 4'd1,
        OP_DPY = 4'd2,
        OP_IDG = 4'd3,
        OP_SDG = 4'd4,
        OP_MOV = 4'd5,
        OP_SHP = 4'd6
    } opcode_e;

    typedef enum logic [3:0] {
        DIR_UP    = 4'd0,
        DIR_RIGHT = 4'd1,
        DIR_DOWN  = 4'd2,
        DIR_LEFT  = 4'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DODGE = 2'd1,
        ST_DEAD  = 2'd2
    } state_e;

endpackage

// File: rtl/player_executor_sat_clamp.sv
// Saturating add/subtract of a delta, clamped to [lo, hi].
// Shared by the X, Y and HP datapaths.
module sat_clamp #(
    parameter int W = 10
) (
    input  logic [W-1:0] i_val,
    input  logic [W-1:0] i_delta,
    input  logic         i_sub,
    input  logic [W-1:0] i_lo,
    input  logic [W-1:0] i_hi,
    output logic [W-1:0] o_res
);

    logic [W:0] w_sum;
    logic [W:0] w_floor;

    // One extra bit keeps the comparisons free of wrap-around
    always_comb begin
        w_sum   = {1'b0, i_val} + {1'b0, i_delta};
        w_floor = {1'b0, i_lo} + {1'b0, i_delta};
        if (i_sub) begin
            o_res = ({1'b0, i_val} < w_floor) ? i_lo : (i_val - i_delta);
        end else begin
            o_res = (w_sum > {1'b0, i_hi}) ? i_hi : w_sum[W-1:0];
        end
    end

endmodule

// File: rtl/player_executor.sv
// Player executor: decodes game instructions into position, HP and
// dodge/death/invulnerability status for the player sprite.
module player_executor
    import player_executor_pkg::*;
#(
    parameter int BOX_LEFT   = 220,
    parameter int BOX_RIGHT  = 420,
    parameter int BOX_TOP    = 260,
    parameter int BOX_BOTTOM = 420,
    parameter int STEP       = 2,
    parameter int MOVE_DIV   = 250000,
    parameter int IFRAME     = 25000000,
    parameter int HP_MAX     = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] playerInstruction,
    input  logic        instrValid,
    output logic        instrReady,
    output logic [9:0]  playerX,
    output logic [9:0]  playerY,
    output logic [7:0]  playerHP,
    output logic        isDeath,
    output logic        isDodging,
    output logic        isInvuln
);

    localparam int MW = $clog2(MOVE_DIV + 1);
    localparam int IW = $clog2(IFRAME + 1);
    localparam logic [9:0] LP_LEFT   = 10'(BOX_LEFT);
    localparam logic [9:0] LP_RIGHT  = 10'(BOX_RIGHT);
    localparam logic [9:0] LP_TOP    = 10'(BOX_TOP);
    localparam logic [9:0] LP_BOTTOM = 10'(BOX_BOTTOM);
    localparam logic [9:0] LP_CX     = 10'((BOX_LEFT + BOX_RIGHT) / 2);
    localparam logic [9:0] LP_CY     = 10'((BOX_TOP + BOX_BOTTOM) / 2);
    localparam logic [9:0] LP_STEP   = 10'(STEP);
    localparam logic [7:0] LP_HPMAX  = 8'(HP_MAX);
    localparam logic [MW-1:0] LP_MOVE = MW'(MOVE_DIV - 1);
    localparam logic [IW-1:0] LP_IFR  = IW'(IFRAME);

    logic [3:0]    w_op;
    logic [3:0]    w_dir;
    logic [7:0]    w_opnd;
    logic          w_acc;

    state_e        r_state;
    state_e        w_state_nx;
    logic [9:0]    r_x;
    logic [9:0]    r_y;
    logic [9:0]    w_x_nx;
    logic [9:0]    w_y_nx;
    logic [9:0]    w_x_mov;
    logic [9:0]    w_y_mov;
    logic [7:0]    r_hp;
    logic [7:0]    w_hp_nx;
    logic [7:0]    w_hp_val;
    logic [7:0]    w_hp_calc;
    logic [MW-1:0] r_move;
    logic [MW-1:0] w_move_nx;
    logic [IW-1:0] r_ifr;
    logic [IW-1:0] w_ifr_nx;
    logic          r_ready;
    logic          r_dead;
    logic          r_dodge;
    logic          r_inv;

    assign w_op   = playerInstruction[15:12];
    assign w_dir  = playerInstruction[11:8];
    assign w_opnd = playerInstruction[7:0];
    assign w_acc  = instrValid & r_ready;

    // SHP computes min(operand, HP_MAX) as 0 + operand saturated
    assign w_hp_val = (w_op == OP_SHP) ? 8'd0 : r_hp;

    sat_clamp #(.W(10)) u_clamp_x (
        .i_val   (r_x),
        .i_delta (LP_STEP),
        .i_sub   (w_dir == DIR_LEFT),
        .i_lo    (LP_LEFT),
        .i_hi    (LP_RIGHT),
        .o_res   (w_x_mov)
    );

    sat_clamp #(.W(10)) u_clamp_y (
        .i_val   (r_y),
        .i_delta (LP_STEP),
        .i_sub   (w_dir == DIR_UP),
        .i_lo    (LP_TOP),
        .i_hi    (LP_BOTTOM),
        .o_res   (w_y_mov)
    );

    sat_clamp #(.W(8)) u_clamp_hp (
        .i_val   (w_hp_val),
        .i_delta (w_opnd),
        .i_sub   (w_op == OP_DPY),
        .i_lo    (8'd0),
        .i_hi    (LP_HPMAX),
        .o_res   (w_hp_calc)
    );

    always_comb begin
        w_state_nx = r_state;
        w_x_nx     = r_x;
        w_y_nx     = r_y;
        w_hp_nx    = r_hp;
        w_move_nx  = (r_move != '0) ? (r_move - MW'(1)) : r_move;
        w_ifr_nx   = (r_ifr != '0) ? (r_ifr - IW'(1)) : r_ifr;
        if (w_acc) begin
            case (w_op)
                OP_HPY: begin
                    if (r_state != ST_DEAD) w_hp_nx = w_hp_calc;
                end
                OP_DPY: begin
                    if (r_state == ST_DODGE && r_ifr == '0) begin
                        w_hp_nx  = w_hp_calc;
                        w_ifr_nx = LP_IFR;
                        if (w_hp_calc == '0) w_state_nx = ST_DEAD;
                    end
                end
                OP_IDG: begin
                    if (r_state != ST_DEAD) begin
                        w_x_nx     = LP_CX;
                        w_y_nx     = LP_CY;
                        w_move_nx  = '0;
                        w_ifr_nx   = '0;
                        w_state_nx = ST_DODGE;
                    end
                end
                OP_SDG: begin
                    if (r_state == ST_DODGE) w_state_nx = ST_IDLE;
                end
                OP_MOV: begin
                    if (r_state == ST_DODGE && r_move == '0 && w_dir < 4'd4) begin
                        w_move_nx = LP_MOVE;
                        if (w_dir == DIR_UP || w_dir == DIR_DOWN) begin
                            w_y_nx = w_y_mov;
                        end else begin
                            w_x_nx = w_x_mov;
                        end
                    end
                end
                OP_SHP: begin
                    w_hp_nx = w_hp_calc;
                    if (r_state == ST_DEAD && w_opnd != 8'd0) begin
                        w_state_nx = ST_IDLE;
                    end else if (r_state == ST_DODGE && w_opnd == 8'd0) begin
                        w_state_nx = ST_DEAD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_x     <= LP_CX;
            r_y     <= LP_CY;
            r_hp    <= LP_HPMAX;
            r_move  <= '0;
            r_ifr   <= '0;
            r_ready <= 1'b0;
            r_dead  <= 1'b0;
            r_dodge <= 1'b0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_x     <= w_x_nx;
            r_y     <= w_y_nx;
            r_hp    <= w_hp_nx;
            r_move  <= w_move_nx;
            r_ifr   <= w_ifr_nx;
            r_ready <= 1'b1;
            r_dead  <= (w_state_nx == ST_DEAD);
            r_dodge <= (w_state_nx == ST_DODGE);
            r_inv   <= (w_ifr_nx != '0);
        end
    end

    assign instrReady = r_ready;
    assign playerX    = r_x;
    assign playerY    = r_y;
    assign playerHP   = r_hp;
    assign isDeath    = r_dead;
    assign isDodging  = r_dodge;
    assign isInvuln   = r_inv;

endmodule

// File: tb/tb_player_executor.sv
// Randomized scoreboard bench for player_executor against an
// integer-level reference model of the instruction rules.
module tb_player_executor;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] hp;
        logic       death;
        logic       dodge;
        logic       inv;
        logic       ready;
    } obs_t;

    localparam int S_IDLE  = 0;
    localparam int S_DODGE = 1;
    localparam int S_DEAD  = 2;
    localparam int MDIV    = 4;
    localparam int IFR     = 8;

    logic        clk;
    logic        rst;
    logic [15:0] playerInstruction;
    logic        instrValid;
    logic        instrReady;
    logic [9:0]  playerX;
    logic [9:0]  playerY;
    logic [7:0]  playerHP;
    logic        isDeath;
    logic        isDodging;
    logic        isInvuln;

    player_executor #(
        .MOVE_DIV (MDIV),
        .IFRAME   (IFR)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .playerInstruction (playerInstruction),
        .instrValid        (instrValid),
        .instrReady        (instrReady),
        .playerX           (playerX),
        .playerY           (playerY),
        .playerHP          (playerHP),
        .isDeath           (isDeath),
        .isDodging         (isDodging),
        .isInvuln          (isInvuln)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_err    = 0;
    obs_t sb[$];

    int m_st, m_x, m_y, m_hp, m_mv, m_if;
    bit m_ready;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.x     = 10'(m_x);
        o.y     = 10'(m_y);
        o.hp    = 8'(m_hp);
        o.death = (m_st == S_DEAD);
        o.dodge = (m_st == S_DODGE);
        o.inv   = (m_if != 0);
        o.ready = m_ready;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o = {playerX, playerY, playerHP, isDeath, isDodging, isInvuln, instrReady};
        return o;
    endfunction

    task automatic compare(input string name, input obs_t got, input obs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got x=%0d y=%0d hp=%0d dead=%b dodge=%b inv=%b rdy=%b want x=%0d y=%0d hp=%0d dead=%b dodge=%b inv=%b rdy=%b",
                     name, got.x, got.y, got.hp, got.death, got.dodge, got.inv, got.ready,
                     exp.x, exp.y, exp.hp, exp.death, exp.dodge, exp.inv, exp.ready);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_x = 320; m_y = 340; m_hp = 100;
        m_mv = 0; m_if = 0; m_ready = 0;
    endtask

    // One clock edge of the reference model
    task automatic model_step(input bit v, input logic [15:0] ins);
        int op, dir, opd, mv_n, if_n;
        op   = int'(ins[15:12]);
        dir  = int'(ins[11:8]);
        opd  = int'(ins[7:0]);
        mv_n = imax(m_mv - 1, 0);
        if_n = imax(m_if - 1, 0);
        if (v && m_ready) begin
            case (op)
                1: if (m_st != S_DEAD) m_hp = imin(m_hp + opd, 100);
                2: if (m_st == S_DODGE && m_if == 0) begin
                    m_hp = imax(m_hp - opd, 0);
                    if_n = IFR;
                    if (m_hp == 0) m_st = S_DEAD;
                end
                3: if (m_st != S_DEAD) begin
                    m_x = 320; m_y = 340; mv_n = 0; if_n = 0; m_st = S_DODGE;
                end
                4: if (m_st == S_DODGE) m_st = S_IDLE;
                5: if (m_st == S_DODGE && m_mv == 0 && dir < 4) begin
                    mv_n = MDIV - 1;
                    case (dir)
                        0: m_y = imax(m_y - 2, 260);
                        1: m_x = imin(m_x + 2, 420);
                        2: m_y = imin(m_y + 2, 420);
                        default: m_x = imax(m_x - 2, 220);
                    endcase
                end
                6: begin
                    m_hp = imin(opd, 100);
                    if (m_st == S_DEAD && opd > 0) m_st = S_IDLE;
                    else if (m_st == S_DODGE && opd == 0) m_st = S_DEAD;
                end
                default: ;
            endcase
        end
        m_mv = mv_n;
        m_if = if_n;
        m_ready = 1;
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic issue(input bit v, input logic [15:0] ins);
        instrValid = v;
        playerInstruction = ins;
        model_step(v, ins);
        sb.push_back(model_obs());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 16'h0000);
    endtask

    // Reset lands between edges and is checked before any edge
    task automatic do_reset(input string name);
        instrValid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare(name, dut_obs(), model_obs());
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                compare("scoreboard", dut_obs(), e);
            end
        end
    end

    initial begin : stim
        int k, op, dir, opd;
        rst = 1'b1;
        instrValid = 1'b0;
        playerInstruction = 16'h0000;
        model_reset();
        @(negedge clk);
        do_reset("reset_initial");

        issue(1'b1, 16'h3000);
        issue(1'b0, 16'h3000);
        issue(1'b1, 16'h5100);
        issue(1'b1, 16'h5100);
        issue(1'b1, 16'h5100);
        issue(1'b0, 16'h0000);
        issue(1'b1, 16'h5100);
        for (int i = 0; i < 42; i++) begin
            issue(1'b1, 16'h5000);
            idle(3);
        end
        for (int i = 0; i < 55; i++) begin
            issue(1'b1, 16'h5300);
            idle(3);
        end
        issue(1'b1, 16'h5900);
        idle(3);
        issue(1'b1, 16'h201E);
        idle(1);
        issue(1'b1, 16'h201E);
        idle(6);
        issue(1'b1, 16'h201E);
        idle(9);
        issue(1'b1, 16'h6014);
        issue(1'b1, 16'h2032);
        issue(1'b1, 16'h5100);
        issue(1'b1, 16'h1032);
        issue(1'b1, 16'h3000);
        issue(1'b1, 16'h6064);
        issue(1'b1, 16'h6032);
        issue(1'b1, 16'h1050);
        issue(1'b1, 16'h3000);
        issue(1'b1, 16'h4000);
        issue(1'b1, 16'h2010);
        issue(1'b1, 16'h3000);
        issue(1'b1, 16'h201E);
        idle(3);
        do_reset("reset_mid_invuln");

        for (int i = 0; i < 4000; i++) begin
            if (i % 700 == 699) do_reset("reset_random");
            k = int'($urandom_range(0, 19));
            if (k <= 9) op = int'($urandom_range(0, 15));
            else if (k <= 15) op = 5;
            else if (k <= 17) op = 2;
            else op = 3;
            dir = int'($urandom_range(0, 5));
            opd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3))
                                               : int'($urandom_range(0, 255));
            issue($urandom_range(0, 3) != 0,
                  {4'(op), 4'(dir), 8'(opd)});
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
